imem_banked_loader: RTL and testbench

- Parametrised successor to the processor's instruction memory.
- Synchronous, registered-read instruction store with a valid/ready fetch port and a separate program-load port, so programs are written at run time instead of being fixed in RTL.
- After reset, a hardware sweep clears every word to NOP (all zeros).
- Sits between the PC/fetch stage and decode; the loader port is driven by the testbench or a boot controller.

---
 rtl/imem_banked_loader_if.sv | 38 +++
 rtl/imem_banked_loader.sv | 135 +++++++++++++
 tb/tb_imem_banked_loader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_banked_loader_if.sv
// Fetch, response and program-load bundle for imem_banked_loader.
// Define IMEM_PARITY_EN to add the inj_par_err parity-fault injection input.
interface imem_if #(
  parameter int INSTR_WIDTH = 19,
  parameter int ADDR_WIDTH  = 12
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [INSTR_WIDTH-1:0] resp_instr;
  logic                   resp_err;
  logic                   ld_valid;
  logic                   ld_ready;
  logic [ADDR_WIDTH-1:0]  ld_addr;
  logic [INSTR_WIDTH-1:0] ld_data;
  logic                   busy;
`ifdef IMEM_PARITY_EN
  logic                   inj_par_err;
`endif

  modport master (
`ifdef IMEM_PARITY_EN
    output inj_par_err,
`endif
    output req_valid, req_addr, resp_ready, ld_valid, ld_addr, ld_data,
    input  req_ready, resp_valid, resp_instr, resp_err, ld_ready, busy
  );

  modport slave (
`ifdef IMEM_PARITY_EN
    input  inj_par_err,
`endif
    input  req_valid, req_addr, resp_ready, ld_valid, ld_addr, ld_data,
    output req_ready, resp_valid, resp_instr, resp_err, ld_ready, busy
  );
endinterface

// File: rtl/imem_banked_loader.sv
// Run-time loadable instruction memory: registered-read fetch port, load port, post-reset clear sweep.
// Optional IMEM_PARITY_EN: per-word even parity, checked on fetch, with fault injection on load.
module imem_banked_loader #(
  parameter int INSTR_WIDTH = 19,
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH       = 4096
) (
  input logic   clk,
  input logic   rst,
  imem_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = INSTR_WIDTH + 1;
`else
  localparam int MEM_W = INSTR_WIDTH;
`endif

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       clr_ptr_q, clr_ptr_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic [INSTR_WIDTH-1:0] resp_instr_q, resp_instr_d;

  logic [MEM_W-1:0]       mem [DEPTH];

  logic             busy, req_ready, ld_ready;
  logic             clr_last, req_fire, ld_fire;
  logic             req_in_range, ld_in_range, par_ok;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [MEM_W-1:0] mem_wdata, rd_word;

  assign clr_last     = (32'(clr_ptr_q) == DEPTH - 1);
  assign req_in_range = (32'(bus.req_addr) < DEPTH);
  assign ld_in_range  = (32'(bus.ld_addr) < DEPTH);
  assign req_fire     = bus.req_valid && req_ready;
  assign ld_fire      = bus.ld_valid && ld_ready;
  assign rd_word      = mem[bus.req_addr[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
  assign par_ok = ~(^rd_word);
`else
  assign par_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_CLEAR;
    else     state_q <= state_d;
  end

  // Next state: the sweep ends after the cycle that clears the last word
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    if (state_q == ST_CLEAR && clr_last) state_d = ST_RUN;
  end

  // Outputs: loads win over fetches; a fetch also waits for a free response slot
  always_comb begin
    busy      = (state_q == ST_CLEAR);
    ld_ready  = (state_q == ST_RUN);
    req_ready = (state_q == ST_RUN) && !bus.ld_valid && (!resp_valid_q || bus.resp_ready);
  end

  always_comb begin
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) clr_ptr_d = clr_ptr_q + 1'b1;
  end

  // Single write port shared by the clear sweep and the loader
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    if (state_q == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (ld_fire && ld_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = bus.ld_addr[IDX_W-1:0];
`ifdef IMEM_PARITY_EN
      mem_wdata = {(^bus.ld_data) ^ bus.inj_par_err, bus.ld_data};
`else
      mem_wdata = bus.ld_data;
`endif
    end
  end

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    if (req_fire) begin
      resp_valid_d = 1'b1;
      if (!req_in_range || !par_ok) begin
        resp_instr_d = '0;
        resp_err_d   = 1'b1;
      end else begin
        resp_instr_d = rd_word[INSTR_WIDTH-1:0];
        resp_err_d   = 1'b0;
      end
    end else if (resp_valid_q && bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_ptr_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      clr_ptr_q    <= clr_ptr_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM; the CLEAR sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.busy       = busy;
  assign bus.ld_ready   = ld_ready;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_instr = resp_instr_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_imem_banked_loader.sv
// Scoreboard bench for imem_banked_loader with DEPTH=16; parity cases build only with IMEM_PARITY_EN.
module tb_imem_banked_loader;
  localparam int IW = 19;
  localparam int AW = 12;
  localparam int DEPTH = 16;

  typedef struct {
    logic [IW-1:0] instr;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t          sb_q[$];
  logic [IW-1:0] model_mem [DEPTH];
  logic          model_bad [DEPTH];

  imem_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  imem_banked_loader #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_fetch(input logic [AW-1:0] a);
    exp_t e;
    logic [3:0] idx;
    idx = a[3:0];
    if (a >= AW'(DEPTH) || model_bad[idx]) begin
      e.instr = '0;
      e.err   = 1'b1;
    end else begin
      e.instr = model_mem[idx];
      e.err   = 1'b0;
    end
    return e;
  endfunction

  // Handshakes are sampled on the falling edge, half a cycle before the edge that commits them
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_instr", 32'(bus.resp_instr), 32'(e.instr));
          check("resp_err", 32'(bus.resp_err), 32'(e.err));
        end
      end
      if (bus.req_valid && bus.req_ready) sb_q.push_back(model_fetch(bus.req_addr));
      if (bus.ld_valid && bus.ld_ready && bus.ld_addr < AW'(DEPTH)) begin
        model_mem[bus.ld_addr[3:0]] = bus.ld_data;
`ifdef IMEM_PARITY_EN
        model_bad[bus.ld_addr[3:0]] = bus.inj_par_err;
`else
        model_bad[bus.ld_addr[3:0]] = 1'b0;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_bad[i] = 1'b0;
    end
  endtask

  // Called just after rst deasserts; counts falling edges with busy high
  task automatic count_busy(input string tag);
    int cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      cycles++;
    end
    check(tag, cycles, DEPTH);
    tick();
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    bit acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    for (int i = 0; i < 50 && !acc; i++) begin
      #1;
      acc = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    check("fetch_accept", 32'(acc), 32'd1);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_addr  = a;
    bus.ld_data  = d;
    tick();
    bus.ld_valid = 1'b0;
  endtask

  task automatic drain();
    bus.resp_ready = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b1;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
`ifdef IMEM_PARITY_EN
    bus.inj_par_err = 1'b0;
`endif
    clear_model();

    // Reset values
    #12;
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_instr", 32'(bus.resp_instr), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    tick();
    rst = 1'b0;
    count_busy("sweep_cycles");

    // Every word reads back as NOP after the sweep
    for (int i = 0; i < DEPTH; i++) fetch(AW'(i));
    drain();

    // Load then fetch on the very next cycle
    load(12'd3, 19'h0A014);
    fetch(12'd3);
    check("ldfetch_valid", 32'(bus.resp_valid), 32'd1);
    check("ldfetch_instr", 32'(bus.resp_instr), 32'h0A014);
    load(12'd4, 19'h12345);
    load(12'd5, 19'h00F0F);
    drain();

    // Backpressure: response held, no new request taken
    bus.resp_ready = 1'b0;
    fetch(12'd3);
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      check("hold_valid", 32'(bus.resp_valid), 32'd1);
      check("hold_instr", 32'(bus.resp_instr), 32'h0A014);
      check("hold_err", 32'(bus.resp_err), 32'd0);
      tick();
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;

    // Streaming: one fetch per cycle, resp_valid stays high
    fetch(12'd3);
    check("stream_valid0", 32'(bus.resp_valid), 32'd1);
    fetch(12'd4);
    check("stream_valid1", 32'(bus.resp_valid), 32'd1);
    fetch(12'd5);
    check("stream_valid2", 32'(bus.resp_valid), 32'd1);
    check("stream_instr2", 32'(bus.resp_instr), 32'h00F0F);
    drain();
    check("drain_valid", 32'(bus.resp_valid), 32'd0);
    check("drain_instr_kept", 32'(bus.resp_instr), 32'h00F0F);

    // Load has priority over a simultaneous fetch
    bus.ld_valid  = 1'b1;
    bus.ld_addr   = 12'd6;
    bus.ld_data   = 19'h1ABCD;
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'd6;
    #1;
    check("prio_stall", 32'(bus.req_ready), 32'd0);
    tick();
    bus.ld_valid = 1'b0;
    #1;
    check("prio_release", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    drain();

    // Out-of-range fetch and dropped out-of-range load (20 aliases 4 if truncated)
    fetch(12'd20);
    check("oor_err", 32'(bus.resp_err), 32'd1);
    check("oor_instr", 32'(bus.resp_instr), 32'd0);
    load(12'd20, 19'h7FFFF);
    fetch(12'd4);
    drain();

`ifdef IMEM_PARITY_EN
    bus.inj_par_err = 1'b1;
    load(12'd5, 19'h0F0F0);
    bus.inj_par_err = 1'b0;
    fetch(12'd5);
    check("par_err", 32'(bus.resp_err), 32'd1);
    check("par_instr", 32'(bus.resp_instr), 32'd0);
    load(12'd8, 19'h0F0F1);
    fetch(12'd8);
    drain();
`endif

    // Reset in the middle of the sweep restarts it from zero
    rst = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("midsweep_busy", 32'(bus.busy), 32'd1);
    tick();
    rst = 1'b0;
    count_busy("resweep_cycles");
    fetch(12'd3);
    fetch(12'd4);
    fetch(12'd6);
    drain();

    // Asynchronous reset clears a pending response immediately
    load(12'd5, 19'h05555);
    bus.resp_ready = 1'b0;
    fetch(12'd5);
    check("pre_rst_valid", 32'(bus.resp_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.resp_valid), 32'd0);
    check("async_rst_instr", 32'(bus.resp_instr), 32'd0);
    clear_model();
    bus.resp_ready = 1'b1;
    tick();
    rst = 1'b0;
    count_busy("post_rst_sweep");
    fetch(12'd5);
    drain();
    repeat (3) tick();

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
